// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and width helper for the up/down counter
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler issuing one tick every PRESCALE enabled clocks
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre;
  assign tick = en && (pre == LAST);
  // prescaler phase: cleared by load, frozen while disabled, wraps after LAST
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else if (clr) pre <= '0;
    else if (en) pre <= tick ? '0 : pre + 1'b1;
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: prescaled up/down counter with load, wrap/saturate and tc/step pulses
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD_MAX = 2**WIDTH - 1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             step
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  logic tick, at_edge;
  logic [WIDTH-1:0] nxt;
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );
  // boundary is tested before the arithmetic so no natural overflow is relied on
  always_comb begin
    at_edge = (dir == DIR_UP) ? (count == MAX) : (count == '0);
    nxt = at_edge ? ((SATURATE == MODE_SAT) ? count : ((dir == DIR_UP) ? '0 : MAX))
                  : ((dir == DIR_UP) ? count + 1'b1 : count - 1'b1);
  end
  // count and pulse registers: load beats step, pulses last one cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= RV;
      tc <= 1'b0;
      step <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
      tc <= 1'b0;
      step <= 1'b0;
    end else begin
      count <= tick ? nxt : count;
      tc <= tick && at_edge;
      step <= tick;
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks over wrap, modulus, saturate and prescale variants
module tb_updown_counter_param;
  logic clk, rst;
  logic [3:0] en, dir, load;
  logic [3:0] lv [4];
  logic [3:0] cnt [4];
  logic [3:0] tc, st;
  int errors = 0;
  int checks = 0;

  updown_counter_param #(.WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .en(en[0]), .dir(dir[0]), .load(load[0]), .load_val(lv[0]),
    .count(cnt[0]), .tc(tc[0]), .step(st[0]));
  updown_counter_param #(.WIDTH(4), .MOD_MAX(9)) u_b (
    .clk(clk), .rst(rst), .en(en[1]), .dir(dir[1]), .load(load[1]), .load_val(lv[1]),
    .count(cnt[1]), .tc(tc[1]), .step(st[1]));
  updown_counter_param #(.WIDTH(4), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en[2]), .dir(dir[2]), .load(load[2]), .load_val(lv[2]),
    .count(cnt[2]), .tc(tc[2]), .step(st[2]));
  updown_counter_param #(.WIDTH(4), .PRESCALE(3)) u_d (
    .clk(clk), .rst(rst), .en(en[3]), .dir(dir[3]), .load(load[3]), .load_val(lv[3]),
    .count(cnt[3]), .tc(tc[3]), .step(st[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int i, input int c, input int t, input int s);
    chk({tag, "_count"}, 32'(cnt[i]), c);
    chk({tag, "_tc"}, 32'(tc[i]), t);
    chk({tag, "_step"}, 32'(st[i]), s);
  endtask

  initial begin
    int e, pe;
    int d_en [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int d_cnt [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
    int d_st [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    en = '0; dir = '0; load = '0;
    for (int i = 0; i < 4; i++) lv[i] = '0;
    rst = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) chk3("reset", i, 0, 0, 0);
    rst = 1'b0;

    en[0] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk3("a_down", 0, (32 - i) % 16, (i == 1 || i == 17) ? 1 : 0, 1);
    end
    en[0] = 1'b0;
    cyc();
    chk3("a_hold", 0, 15, 0, 0);

    en[1] = 1'b1; dir[1] = 1'b1;
    e = 0;
    for (int i = 0; i < 20; i++) begin
      pe = e;
      e = (e == 9) ? 0 : e + 1;
      cyc();
      chk3("b_up", 1, e, (pe == 9) ? 1 : 0, 1);
    end
    en[1] = 1'b0; load[1] = 1'b1; lv[1] = 4'd12;
    cyc();
    chk3("b_clamp", 1, 9, 0, 0);
    load[1] = 1'b0;

    load[2] = 1'b1; lv[2] = 4'd13;
    cyc();
    chk("c_load", 32'(cnt[2]), 13);
    load[2] = 1'b0; en[2] = 1'b1; dir[2] = 1'b1;
    cyc(); chk3("c_14", 2, 14, 0, 1);
    cyc(); chk3("c_15", 2, 15, 0, 1);
    cyc(); chk3("c_sat1", 2, 15, 1, 1);
    cyc(); chk3("c_sat2", 2, 15, 1, 1);
    en[2] = 1'b0; load[2] = 1'b1; lv[2] = 4'd0;
    cyc();
    load[2] = 1'b0; en[2] = 1'b1; dir[2] = 1'b0;
    cyc(); chk3("c_sat0", 2, 0, 1, 1);
    en[2] = 1'b0;

    dir[3] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en[3] = d_en[i][0];
      cyc();
      chk3($sformatf("d_pre%0d", i), 3, d_cnt[i], 0, d_st[i]);
    end
    en[3] = 1'b1;
    cyc();
    chk3("d_mid", 3, 3, 0, 0);
    load[3] = 1'b1; lv[3] = 4'd5;
    cyc();
    chk3("d_load", 3, 5, 0, 0);
    load[3] = 1'b0;
    cyc(); chk3("d_r1", 3, 5, 0, 0);
    cyc(); chk3("d_r2", 3, 5, 0, 0);
    cyc(); chk3("d_r3", 3, 6, 0, 1);
    en[3] = 1'b0;

    load[0] = 1'b1; lv[0] = 4'd15;
    cyc();
    chk("a_ld15", 32'(cnt[0]), 15);
    en[0] = 1'b1; dir[0] = 1'b1; lv[0] = 4'd7;
    cyc();
    chk3("a_ldtick", 0, 7, 0, 0);
    load[0] = 1'b0; dir[0] = 1'b0;
    cyc();
    chk3("a_dirchg", 0, 6, 0, 1);
    en[0] = 1'b0;

    load[3] = 1'b1; lv[3] = 4'd11;
    cyc();
    load[3] = 1'b0;
    chk("d_ld11", 32'(cnt[3]), 11);
    en[3] = 1'b1; dir[3] = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1 chk3("d_async", 3, 0, 0, 0);
    cyc();
    rst = 1'b0;
    cyc(); chk3("d_post1", 3, 0, 0, 0);
    cyc(); chk3("d_post2", 3, 0, 0, 0);
    cyc(); chk3("d_post3", 3, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit down counter.
- Configurable width and modulus; runtime up/down direction; synchronous load; count enable; clock prescaler; wrap or saturate mode; registered terminal-count pulse.
- Used as the general timing/event counter in designs that previously instantiated the fixed down counter.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- MOD_MAX, 2**WIDTH-1, highest count value; range is 0..MOD_MAX, with MOD_MAX ≤ 2**WIDTH-1.
- RESET_VAL, 0, count value after reset; must be ≤ MOD_MAX.
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.
- PRESCALE, 1, enabled clocks per count step (≥1); 1 = step every enabled clock.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes both the count and the prescaler.
- dir  in  1  1 = count up, 0 = count down; sampled on each step edge.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).
- step  out  1  registered; high for the cycle following each edge on which a step occurred.

Behaviour:
- Reset (asserts asynchronously, releases synchronously to the design):
  - count = RESET_VAL, tc = 0, step = 0, prescaler = 0.
- Priority per edge: rst > load > step > hold.
- Load:
  - count <= min(load_val, MOD_MAX); prescaler <= 0; tc <= 0; step <= 0.
  - load works regardless of en.
- Tick:
  - Internal prescaler counts 0..PRESCALE-1 while en = 1.
  - tick = en && (prescaler == PRESCALE-1); prescaler then returns to 0.
  - PRESCALE = 1 gives tick = en.
- Step, on a tick edge without load:
  - dir = 1, count < MOD_MAX: count + 1.
  - dir = 1, count == MOD_MAX: wrap mode -> 0; saturate mode -> hold.
  - dir = 0, count > 0: count - 1.
  - dir = 0, count == 0: wrap mode -> MOD_MAX; saturate mode -> hold.
- tc: 1 for exactly one cycle after any step taken at a boundary (wrap, or attempted overflow/underflow in saturate mode); 0 otherwise.
- step: 1 for exactly one cycle after every tick edge without load, including saturated holds.
- en = 0: count, prescaler and outputs hold; tc = 0 and step = 0 on the next edge.
- Direction change: takes effect at the next tick only. A partial prescale interval is not reset.
- Non-power-of-two MOD_MAX: values above MOD_MAX are unreachable except via load, which clamps.
- Arithmetic: unsigned, WIDTH bits. The boundary compare happens before increment/decrement, so there is no natural-overflow reliance.
- Mid-operation reset: immediately forces reset values; no pending tick or tc survives.
- Latency: load/step to count = 1 clock. tc and step are coincident with the new count value.

Decomposition:
- Package counter_pkg:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - MODE_WRAP = 0, MODE_SAT = 1.
  - Function clog2 for the prescaler width.
- Sub-module tick_gen (params PRESCALE; ports clk, rst, en, clr, tick): the prescaler. clr is driven by load.
- Counter core and tc/step registers live in the top module.

Test Plan:
- Reset, WIDTH=4, MOD_MAX=15, dir=0, en=1, PRESCALE=1 -> count 0 -> 15 (tc=1 that cycle) -> 14 ... -> 0 -> 15 (tc=1 again), with a 16-cycle period.
- MOD_MAX=9, dir=1, wrap mode -> 0..9 then 0. tc high only coincident with each 9->0 wrap. load_val=12 -> count=9.
- SATURATE=1, dir=1, from 13 -> 14, 15, 15, 15. tc=1 on each hold at 15. step=1 every cycle.
- PRESCALE=3, en=1, dir=1 from 0 -> count changes every 3rd clock. Drop en for 2 cycles mid-interval -> the interval stretches by 2. Assert load=1, load_val=5 -> count=5 and the prescaler restarts.
- Simultaneous load and tick at a boundary (count=15, dir=1, load_val=7) -> count=7, tc=0. Toggle dir at count=7 -> next tick gives 6.
- Assert rst asynchronously between edges while count=11 -> count=RESET_VAL immediately and tc=0. After release, counting resumes with a full prescale interval.
